// File: rtl/opti_mult_pipe.sv
// Pipelined signed multiplier with optional round/shift scaling and saturating or wrapping narrowing.
// Every stage advances together under a single enable, so stalls ripple back to in_ready combinationally.
module opti_mult_pipe #(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 0,
  parameter int SAT    = 1,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   p,
  output logic               ovf,
  output logic               ovf_sticky,
  input  logic               clr,
  output logic               busy
);

  localparam int P_W      = A_W + B_W;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [P_W:0] RND_ADD =
    ((ROUND != 0) && (SHIFT > 0)) ? ((P_W+1)'(1) << SHIFT_M1) : '0;
  // One guard bit above the product keeps the rounding add from overflowing.
  localparam logic signed [P_W:0] MAX_V = {{(P_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W:0] MIN_V = {{(P_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [P_W-1:0] prod;
  logic signed [P_W:0]   rounded;
  logic signed [P_W:0]   shifted;
  logic                  over;
  logic                  under;
  logic [OUT_W-1:0]      p_next;
  logic                  ovf_next;
  logic                  adv;

  logic [STAGES-1:0]     stg_valid;
  logic [STAGES-1:0]     stg_ovf;
  logic [OUT_W-1:0]      stg_p [STAGES];

  assign prod    = P_W'($signed(a)) * P_W'($signed(b));
  assign rounded = {prod[P_W-1], prod} + RND_ADD;
  assign shifted = rounded >>> SHIFT;
  assign over    = shifted > MAX_V;
  assign under   = shifted < MIN_V;

  always_comb begin
    p_next   = shifted[OUT_W-1:0];
    ovf_next = over | under;
    if (SAT != 0) begin
      if (over) begin
        p_next = MAX_V[OUT_W-1:0];
      end else if (under) begin
        p_next = MIN_V[OUT_W-1:0];
      end
    end
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // the pipeline moves whenever the output slot is empty or being consumed.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid  <= '0;
      stg_ovf    <= '0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        stg_p[i] <= '0;
      end
    end else begin
      if (adv) begin
        stg_valid[0] <= in_valid;
        stg_p[0]     <= p_next;
        stg_ovf[0]   <= ovf_next;
        for (int i = 1; i < STAGES; i++) begin
          stg_valid[i] <= stg_valid[i-1];
          stg_p[i]     <= stg_p[i-1];
          stg_ovf[i]   <= stg_ovf[i-1];
        end
      end
      if (clr) begin
        ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && ovf) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign p         = stg_p[STAGES-1];
  assign ovf       = stg_ovf[STAGES-1];
  assign busy      = |stg_valid;

endmodule

// File: tb/tb_opti_mult_pipe.sv
// Bench for opti_mult_pipe: default, saturating Q15 and wrapping Q15 instances share one stimulus stream.
module tb_opti_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        clr;
  logic [15:0] a;
  logic [15:0] b;

  logic        d_in_ready, d_out_valid, d_ovf, d_sticky, d_busy;
  logic [31:0] d_p;
  logic        s_in_ready, s_out_valid, s_ovf, s_sticky, s_busy;
  logic [15:0] s_p;
  logic        w_in_ready, w_out_valid, w_ovf, w_sticky, w_busy;
  logic [15:0] w_p;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [98:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [32:0] stall_val;

  always #5 clk = ~clk;

  opti_mult_pipe u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .a(a), .b(b),
    .out_valid(d_out_valid), .out_ready(out_ready), .p(d_p), .ovf(d_ovf),
    .ovf_sticky(d_sticky), .clr(clr), .busy(d_busy));

  opti_mult_pipe #(.OUT_W(16), .SHIFT(15), .ROUND(1), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .p(s_p), .ovf(s_ovf),
    .ovf_sticky(s_sticky), .clr(clr), .busy(s_busy));

  opti_mult_pipe #(.OUT_W(16), .SHIFT(15), .ROUND(0), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .a(a), .b(b),
    .out_valid(w_out_valid), .out_ready(out_ready), .p(w_p), .ovf(w_ovf),
    .ovf_sticky(w_sticky), .clr(clr), .busy(w_busy));

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, result zero-extended to 32 bits}
  function automatic logic [32:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input int out_w, input int shift,
                                        input int rnd, input int sat);
    longint pr, mx, mn;
    logic ov;
    logic [31:0] r;
    pr = longint'($signed(ma)) * longint'($signed(mb));
    if (rnd != 0 && shift > 0) pr = pr + (longint'(1) <<< (shift - 1));
    pr = pr >>> shift;
    mx = (longint'(1) <<< (out_w - 1)) - 1;
    mn = -mx - 1;
    ov = (pr > mx) || (pr < mn);
    if (sat != 0 && pr > mx) pr = mx;
    else if (sat != 0 && pr < mn) pr = mn;
    r = 32'(pr);
    if (out_w < 32) r = r & ((32'd1 << out_w) - 32'd1);
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    logic [98:0] e;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && d_out_valid) check("hold_p", {d_ovf, d_p}, stall_val);
      stall_prev = d_out_valid && !out_ready;
      stall_val  = {d_ovf, d_p};
      if (d_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_pending", 33'(exp_q.size() != 0), 33'd1);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("sb_def", {d_ovf, d_p}, e[98:66]);
          check("sb_sat", {s_ovf, 16'h0, s_p}, e[65:33]);
          check("sb_wrap", {w_ovf, 16'h0, w_p}, e[32:0]);
          check("sb_sat_valid", 33'(s_out_valid), 33'd1);
          check("sb_wrap_valid", 33'(w_out_valid), 33'd1);
        end
      end
      if (in_valid && d_in_ready) begin
        exp_q.push_back({model(a, b, 32, 0, 0, 1), model(a, b, 16, 15, 1, 1),
                         model(a, b, 16, 15, 0, 0)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || d_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    int c;
    int i;
    int pop0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("rst_out_valid", 33'(d_out_valid), 33'd0);
    check("rst_busy", 33'(d_busy), 33'd0);
    check("rst_sticky", 33'(d_sticky), 33'd0);
    check("rst_p_ovf", {d_ovf, d_p}, 33'd0);
    rst_n = 1'b1;
    check("post_rst_in_ready", 33'(d_in_ready), 33'd1);

    // 0x4000 * 0x4000 through the default instance: two-cycle latency, single pulse
    a = 16'h4000; b = 16'h4000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_c1_valid", 33'(d_out_valid), 33'd0);
    tick();
    check("lat_c2_valid", 33'(d_out_valid), 33'd1);
    check("lat_c2_p", {d_ovf, d_p}, {1'b0, 32'h1000_0000});
    tick();
    check("lat_c3_valid", 33'(d_out_valid), 33'd0);

    // Most-negative squared overflows Q15
    a = 16'h8000; b = 16'h8000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("sat_p", {s_ovf, 16'h0, s_p}, {1'b1, 32'h0000_7FFF});
    check("wrap_p", {w_ovf, 16'h0, w_p}, {1'b1, 32'h0000_8000});
    tick();
    check("sat_sticky", 33'(s_sticky), 33'd1);
    check("wrap_sticky", 33'(w_sticky), 33'd1);
    check("def_sticky", 33'(d_sticky), 33'd0);

    // Rounding boundaries
    a = 16'h0001; b = 16'h4000; in_valid = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'h4000;
    tick();
    in_valid = 1'b0;
    check("rnd_pos_sat", {s_ovf, 16'h0, s_p}, {1'b0, 32'h0000_0001});
    check("rnd_pos_wrap", {w_ovf, 16'h0, w_p}, {1'b0, 32'h0000_0000});
    tick();
    check("rnd_neg_sat", {s_ovf, 16'h0, s_p}, {1'b0, 32'h0000_0000});
    wait_drain(10);

    // clr coincides with an accepted overflowing result
    a = 16'h8000; b = 16'h8000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_wins_sat", 33'(s_sticky), 33'd0);
    check("clr_wins_wrap", 33'(w_sticky), 33'd0);
    tick();
    check("clr_hold_sat", 33'(s_sticky), 33'd0);

    // Back-to-back stream with a three-cycle downstream stall
    pop0 = n_pop;
    c = 0;
    i = 0;
    while (i < 8 && c < 50) begin
      in_valid = 1'b1; a = 16'(i); b = 16'd3;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      check("stream_in_ready", 33'(d_in_ready), 33'(!(c >= 3 && c <= 5)));
      if (d_in_ready) i++;
      tick();
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(20);
    check("stream_count", 33'(n_pop - pop0), 33'd8);

    // Reset with two results in flight
    pop0 = n_pop;
    a = 16'd5; b = 16'd7; in_valid = 1'b1;
    tick();
    a = 16'd6;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out_valid", 33'(d_out_valid), 33'd0);
    check("mid_rst_busy", 33'(d_busy), 33'd0);
    repeat (5) begin
      tick();
      check("no_stale", 33'(d_out_valid), 33'd0);
    end
    check("mid_rst_count", 33'(n_pop - pop0), 33'd0);

    // Random traffic with random back-pressure
    repeat (60) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom_range(0, 65535));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opti_mult_pipe.md
OPTI_MULT_PIPE -- requirements
Module: opti_mult_pipe

Interface
REQ-001 Parameter A_W, default 16, SHALL set signed operand a width.
REQ-002 Parameter B_W, default 16, SHALL set signed operand b width.
REQ-003 Parameter OUT_W, default 32, SHALL set result width; legal range 2..A_W+B_W.
REQ-004 Parameter SHIFT, default 0, SHALL set the arithmetic right shift applied to the full product; legal range 0..A_W+B_W-2.
REQ-005 Parameter ROUND, default 0, SHALL select round-half-up (1) or truncate (0) on the shift.
REQ-006 Parameter SAT, default 1, SHALL select saturation (1) or wrap (0) on narrowing to OUT_W.
REQ-007 Parameter STAGES, default 2, SHALL set pipeline depth; legal range 1..4.
REQ-008 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-009 Port rst_n, input, 1, SHALL be the reset: synchronous and active-low.
REQ-010 Port in_valid, input, 1, SHALL qualify a and b.
REQ-011 Port in_ready, output, 1, SHALL indicate that an operand pair is accepted this cycle.
REQ-012 Port a, input, A_W, SHALL be the signed multiplicand.
REQ-013 Port b, input, B_W, SHALL be the signed multiplier.
REQ-014 Port out_valid, output, 1, SHALL qualify p and ovf.
REQ-015 Port out_ready, input, 1, SHALL be the downstream acceptance.
REQ-016 Port p, output, OUT_W, SHALL be the signed, scaled result.
REQ-017 Port ovf, output, 1, SHALL flag that p was saturated or wrapped for this result.
REQ-018 Port ovf_sticky, output, 1, SHALL be the OR of all ovf values accepted since reset or since the last clr.
REQ-019 Port clr, input, 1, SHALL clear ovf_sticky synchronously.
REQ-020 Port busy, output, 1, SHALL be high while any pipeline stage holds valid data.

Function
REQ-021 Product: full-precision signed a*b of A_W+B_W bits; no intermediate truncation.
REQ-022 Scaling: if ROUND=1, add 2^(SHIFT-1) before the arithmetic right shift by SHIFT; the add is a no-op when SHIFT=0.
REQ-023 Narrowing: if the scaled value exceeds the OUT_W signed range, SAT=1 SHALL clamp it to +max/-min and SAT=0 SHALL keep the low OUT_W bits; ovf SHALL be 1 in both cases.
REQ-024 Pipeline: STAGES register stages, each holding {valid, data, ovf}; global advance enable adv = out_ready | ~out_valid.
REQ-025 in_ready SHALL equal adv (combinational); a transfer occurs when in_valid & in_ready.
REQ-026 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready is held at 1; throughput SHALL be 1 result per cycle.
REQ-027 When adv=0, all stages SHALL hold their contents; p and ovf SHALL stay stable while out_valid=1 & out_ready=0.
REQ-028 Bubbles (in_valid=0 while adv=1) SHALL propagate as valid=0 entries; results SHALL never be duplicated, dropped or reordered.
REQ-029 ovf_sticky SHALL be set on any out_valid & out_ready cycle with ovf=1; if clr is asserted in the same cycle, clr SHALL win.
REQ-030 busy SHALL be the OR of all stage valid bits.

Reset
REQ-031 When rst_n=0 at a clock edge, all stage valid bits, out_valid, p, ovf, ovf_sticky and busy SHALL become 0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight results; none SHALL emerge after reset is released.
REQ-033 in_ready SHALL be 1 in the first cycle after reset, because out_valid is 0.

Verification
REQ-034 Defaults, a=0x4000, b=0x4000, out_ready=1 -> two cycles later p=0x10000000, ovf=0, out_valid high for 1 cycle.
REQ-035 OUT_W=16, SHIFT=15, SAT=1, a=0x8000, b=0x8000 -> p=0x7FFF, ovf=1, ovf_sticky=1; with SAT=0 -> p=0x8000, ovf=1.
REQ-036 OUT_W=16, SHIFT=15: a=0x0001, b=0x4000 -> p=0x0001 when ROUND=1 and p=0x0000 when ROUND=0; a=0xFFFF, b=0x4000, ROUND=1 -> p=0x0000.
REQ-037 Back-to-back stream of 8 pairs (a=i, b=3) with out_ready low for cycles 3..5 -> in_ready low in the same cycles; outputs in order 0,3,...,21 with no loss or duplication.
REQ-038 rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0 and busy=0 next cycle; no stale results afterwards.
REQ-039 clr asserted in the same cycle as an accepted ovf=1 result -> ovf_sticky=0 next cycle.
